// File: rtl/mem_arbiter_if.sv
// Cache-side, memory-side and status signals of the two-port line-fill arbiter.
// The arbiter uses the slave modport; the cache/memory environment uses the master modport.
interface mem_arbiter_if #(
   parameter int unsigned AW = 14,
   parameter int unsigned DW = 32
);
   logic          s0_stb;
   logic [AW-1:0] s0_addr;
   logic [DW-1:0] s0_data;
   logic          s0_ack;
   logic          s1_stb;
   logic [AW-1:0] s1_addr;
   logic [DW-1:0] s1_data;
   logic          s1_ack;
   logic          m_stb;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_ack;
   logic          grant;
   logic          busy;

   modport slave (
      input  s0_stb, s0_addr, s1_stb, s1_addr, m_data, m_ack,
      output s0_data, s0_ack, s1_data, s1_ack, m_stb, m_addr, grant, busy
   );

   modport master (
      output s0_stb, s0_addr, s1_stb, s1_addr, m_data, m_ack,
      input  s0_data, s0_ack, s1_data, s1_ack, m_stb, m_addr, grant, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory read port between the I-cache (port 0) and D-cache (port 1).
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 wins every tie.
module mem_arbiter #(
   parameter int unsigned AW = 14,
   parameter int unsigned DW = 32
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e        state_q, state_d;
   logic          grant_q, grant_d;
   logic          last_q, last_d;
   logic          sel_stb;
   logic          fwd_stb;
   logic [AW-1:0] fwd_addr;
   logic          ack0, ack1;
   logic [DW-1:0] rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      sel_stb  = 1'b0;
      fwd_stb  = 1'b0;
      fwd_addr = '0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.s0_stb || bus.s1_stb) begin
               state_d = BUSY;
`ifdef MEM_ARB_RR_EN
               grant_d = (bus.s0_stb && bus.s1_stb) ? ~last_q : bus.s1_stb;
`else
               grant_d = ~bus.s0_stb;
`endif
            end
         end
         BUSY: begin
            sel_stb  = grant_q ? bus.s1_stb : bus.s0_stb;
            fwd_stb  = sel_stb;
            fwd_addr = grant_q ? bus.s1_addr : bus.s0_addr;
            // An ack coinciding with reset is swallowed: the transaction is being torn down.
            if (bus.m_ack && !rst) begin
               ack0    = ~grant_q;
               ack1    = grant_q;
               state_d = IDLE;
               last_d  = grant_q;
            end else if (!sel_stb) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rdata       = bus.m_data;
   assign bus.s0_data = rdata;
   assign bus.s1_data = rdata;
   assign bus.s0_ack  = ack0;
   assign bus.s1_ack  = ack1;
   assign bus.m_stb   = fwd_stb;
   assign bus.m_addr  = fwd_addr;
   assign bus.grant   = grant_q;
   assign bus.busy    = (state_q == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven request patterns plus hand-written
// multi-cycle sequences, with a scoreboard of expected acks.
module tb_mem_arbiter;

   typedef struct {
      bit          r0;
      bit          r1;
      logic [13:0] a0;
      logic [13:0] a1;
      int          lat;
   } vec_t;

   typedef struct {
      bit          port;
      logic [13:0] addr;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   fails;
   int   cyc;

   bit          mem_auto;
   int          mem_lat;
   int          mcnt;
   bit          man_ack;
   logic [31:0] man_data;
   bit          rst_pend;
   bit          drop0, drop1;
   bit          last_m;
   exp_t        sb[$];

   mem_arbiter_if #(.AW(14), .DW(32)) bus ();

   mem_arbiter #(.AW(14), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [13:0] a);
      return {~a[7:0], a, 10'h155};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: requesters and memory react after the edge, outputs checked at the falling edge.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      rst = rst_pend;
      if (drop0) begin bus.s0_stb = 1'b0; drop0 = 1'b0; end
      if (drop1) begin bus.s1_stb = 1'b0; drop1 = 1'b0; end
      #1;
      bus.m_ack = 1'b0;
      if (mem_auto) begin
         if (bus.m_stb && !rst) begin
            if (mcnt >= mem_lat - 1) begin
               bus.m_ack  = 1'b1;
               bus.m_data = mem_word(bus.m_addr);
               mcnt = 0;
            end else begin
               mcnt++;
            end
         end else begin
            mcnt = 0;
         end
      end else begin
         bus.m_ack  = man_ack;
         bus.m_data = man_data;
         man_ack    = 1'b0;
      end
      @(negedge clk);
      cyc++;
      chk("ack_exclusive", {31'd0, bus.s0_ack & bus.s1_ack}, 32'd0);
      if (bus.s0_ack || bus.s1_ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", {30'd0, bus.s1_ack, bus.s0_ack}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_port", {31'd0, bus.s1_ack}, {31'd0, e.port});
            chk("ack_grant", {31'd0, bus.grant}, {31'd0, e.port});
            chk("ack_addr", {18'd0, bus.m_addr}, {18'd0, e.addr});
            chk("s0_data", bus.s0_data, e.data);
            chk("s1_data", bus.s1_data, e.data);
            if (bus.s1_ack) drop1 = 1'b1;
            else            drop0 = 1'b1;
         end
      end
   endtask

   task automatic push(input bit port, input logic [13:0] addr, input logic [31:0] data);
      exp_t e;
      e.port = port;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
   endtask

   vec_t vecs[8];

   initial begin
      bit first;
      int n;
      checks = 0; fails = 0; cyc = 0;
      rst = 1'b1; rst_pend = 1'b1;
      mem_auto = 1'b1; mem_lat = 1; mcnt = 0;
      man_ack = 1'b0; man_data = '0;
      drop0 = 1'b0; drop1 = 1'b0; last_m = 1'b1;
      bus.s0_stb = 1'b0; bus.s0_addr = '0;
      bus.s1_stb = 1'b0; bus.s1_addr = '0;
      bus.m_ack = 1'b0; bus.m_data = '0;

      vecs[0] = '{r0: 1, r1: 0, a0: 14'h0123, a1: 14'h0000, lat: 3};
      vecs[1] = '{r0: 0, r1: 1, a0: 14'h0000, a1: 14'h3FFF, lat: 1};
      vecs[2] = '{r0: 1, r1: 1, a0: 14'h0001, a1: 14'h0002, lat: 2};
      vecs[3] = '{r0: 1, r1: 1, a0: 14'h1000, a1: 14'h2000, lat: 1};
      vecs[4] = '{r0: 1, r1: 0, a0: 14'h0ABC, a1: 14'h0000, lat: 1};
      vecs[5] = '{r0: 1, r1: 1, a0: 14'h0F0F, a1: 14'h30F0, lat: 2};
      vecs[6] = '{r0: 1, r1: 0, a0: 14'h0000, a1: 14'h0000, lat: 4};
      vecs[7] = '{r0: 0, r1: 1, a0: 14'h0000, a1: 14'h1555, lat: 2};

      // Reset held for two cycles
      step();
      step();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_m_stb", {31'd0, bus.m_stb}, 32'd0);
      chk("rst_s0_ack", {31'd0, bus.s0_ack}, 32'd0);
      chk("rst_s1_ack", {31'd0, bus.s1_ack}, 32'd0);
      chk("rst_grant", {31'd0, bus.grant}, 32'd0);
      rst_pend = 1'b0;
      step();

      // Table-driven request patterns against the auto-responding memory
      for (int i = 0; i < 8; i++) begin
         mem_lat = vecs[i].lat;
         bus.s0_stb  = vecs[i].r0;
         bus.s0_addr = vecs[i].a0;
         bus.s1_stb  = vecs[i].r1;
         bus.s1_addr = vecs[i].a1;
         if (vecs[i].r0 && vecs[i].r1) begin
`ifdef MEM_ARB_RR_EN
            first = ~last_m;
`else
            first = 1'b0;
`endif
            push(first, first ? vecs[i].a1 : vecs[i].a0, mem_word(first ? vecs[i].a1 : vecs[i].a0));
            push(~first, first ? vecs[i].a0 : vecs[i].a1, mem_word(first ? vecs[i].a0 : vecs[i].a1));
            last_m = ~first;
         end else begin
            first = vecs[i].r1;
            push(first, first ? vecs[i].a1 : vecs[i].a0, mem_word(first ? vecs[i].a1 : vecs[i].a0));
            last_m = first;
         end
         n = 0;
         while (sb.size() != 0 && n < 60) begin
            step();
            n++;
         end
         if (sb.size() != 0) begin
            chk("vec_timeout", sb.size(), 32'd0);
            sb.delete();
            bus.s0_stb = 1'b0;
            bus.s1_stb = 1'b0;
         end
         step();
         chk("vec_idle_busy", {31'd0, bus.busy}, 32'd0);
         chk("vec_idle_m_stb", {31'd0, bus.m_stb}, 32'd0);
      end

      // Latency and overlap: port 1 waits behind port 0, forwarded two cycles after s0_ack
      mem_auto = 1'b0;
      bus.s0_stb = 1'b1; bus.s0_addr = 14'h0123;
      push(1'b0, 14'h0123, 32'hDEADBEEF);
      chk("lat_m_stb_n", {31'd0, bus.m_stb}, 32'd0);
      step();
      chk("lat_m_stb_n1", {31'd0, bus.m_stb}, 32'd1);
      chk("lat_m_addr", {18'd0, bus.m_addr}, 32'h0123);
      chk("lat_busy", {31'd0, bus.busy}, 32'd1);
      bus.s1_stb = 1'b1; bus.s1_addr = 14'h3FFF;
      push(1'b1, 14'h3FFF, 32'hCAFEF00D);
      step();
      chk("ovl_hold_addr", {18'd0, bus.m_addr}, 32'h0123);
      chk("ovl_hold_grant", {31'd0, bus.grant}, 32'd0);
      man_ack = 1'b1; man_data = 32'hDEADBEEF;
      step();
      chk("ovl_s0_acked", sb.size(), 32'd1);
      step();
      chk("ovl_k1_busy", {31'd0, bus.busy}, 32'd0);
      chk("ovl_k1_m_stb", {31'd0, bus.m_stb}, 32'd0);
      step();
      chk("ovl_k2_m_stb", {31'd0, bus.m_stb}, 32'd1);
      chk("ovl_k2_m_addr", {18'd0, bus.m_addr}, 32'h3FFF);
      chk("ovl_k2_grant", {31'd0, bus.grant}, 32'd1);
      man_ack = 1'b1; man_data = 32'hCAFEF00D;
      step();
      chk("ovl_s1_acked", sb.size(), 32'd0);
      step();
      chk("ovl_end_busy", {31'd0, bus.busy}, 32'd0);

      // Abandon: port 1 drops its request before memory answers
      bus.s1_stb = 1'b1; bus.s1_addr = 14'h0777;
      step();
      chk("abn_busy", {31'd0, bus.busy}, 32'd1);
      chk("abn_grant", {31'd0, bus.grant}, 32'd1);
      chk("abn_m_stb", {31'd0, bus.m_stb}, 32'd1);
      bus.s1_stb = 1'b0;
      step();
      chk("abn_idle", {31'd0, bus.busy}, 32'd0);
      chk("abn_no_ack", {30'd0, bus.s1_ack, bus.s0_ack}, 32'd0);
      man_ack = 1'b1; man_data = 32'h12345678;
      step();
      chk("abn_late_ack", {30'd0, bus.s1_ack, bus.s0_ack}, 32'd0);
      chk("abn_late_m_stb", {31'd0, bus.m_stb}, 32'd0);

      // Reset coincident with m_ack while busy
      bus.s0_stb = 1'b1; bus.s0_addr = 14'h0042;
      step();
      chk("rmo_busy", {31'd0, bus.busy}, 32'd1);
      rst_pend = 1'b1;
      man_ack = 1'b1; man_data = 32'hA5A5A5A5;
      step();
      chk("rmo_no_ack", {30'd0, bus.s1_ack, bus.s0_ack}, 32'd0);
      bus.s0_stb = 1'b0;
      rst_pend = 1'b0;
      step();
      chk("rmo_busy_after", {31'd0, bus.busy}, 32'd0);
      chk("rmo_m_stb_after", {31'd0, bus.m_stb}, 32'd0);
      chk("rmo_sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
